// File: rtl/pc_next_unit.sv
// Fetch-side program counter and next-PC selector.
// Combines D-stage branch/jump decode, comparator codes and CP0 redirects
// into the next F-stage PC, and flags fetch address errors and delay slots.

`ifndef CMP_EQ
`define CMP_EQ  2'd0
`define CMP_GT  2'd1
`define CMP_LT  2'd2
`endif
`ifndef ZERO_EQ
`define ZERO_EQ 2'd0
`define ZERO_GT 2'd1
`define ZERO_LT 2'd2
`endif

module pc_next_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] EXC_PC   = 32'h0000_4180,
   parameter logic [31:0] IM_LO    = 32'h0000_3000,
   parameter logic [31:0] IM_HI    = 32'h0000_6ffc
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [31:0] d_pc,
   input  logic [2:0]  br_op,
   input  logic [1:0]  cmp,
   input  logic [1:0]  zero,
   input  logic [15:0] imm16,
   input  logic [1:0]  j_op,
   input  logic [25:0] instr_index,
   input  logic [31:0] jr_target,
   input  logic        exc_req,
   input  logic        eret,
   input  logic [31:0] epc,
   output logic [31:0] pc,
   output logic [31:0] link_addr,
   output logic        br_taken,
   output logic        f_bd,
   output logic        adel_f
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [31:0] d_pc_plus4;
   logic [31:0] br_target;
   logic [31:0] j_target;
   logic        is_branch;
   logic        is_jump;

   assign d_pc_plus4 = d_pc + 32'd4;
   assign link_addr  = d_pc + 32'd8;
   assign br_target  = d_pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
   assign j_target   = {d_pc_plus4[31:28], instr_index, 2'b00};
   assign pc         = pc_q;

   // Branch condition from the comparator codes; reserved encodings never take.
   always_comb begin
      br_taken = 1'b0;
      case (br_op)
         3'd1:    br_taken = (cmp == `CMP_EQ);
         3'd2:    br_taken = (cmp != `CMP_EQ);
         3'd3:    br_taken = (zero == `ZERO_EQ) || (zero == `ZERO_LT);
         3'd4:    br_taken = (zero == `ZERO_GT);
         3'd5:    br_taken = (zero == `ZERO_LT);
         3'd6:    br_taken = (zero == `ZERO_EQ) || (zero == `ZERO_GT);
         default: br_taken = 1'b0;
      endcase
   end

   // Delay-slot flag: any non-reserved branch or jump currently in D.
   always_comb begin
      is_branch = (br_op != 3'd0) && (br_op != 3'd7);
      is_jump   = (j_op == 2'd1) || (j_op == 2'd2);
      f_bd      = is_branch || is_jump;
   end

   // Fetch address error on misalignment or out-of-range instruction memory.
   always_comb begin
      adel_f = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);
   end

   // Next-PC priority: CP0 redirects bypass stall, then jumps, branch, sequential.
   always_comb begin
      pc_d = pc_q + 32'd4;
      if (exc_req) begin
         pc_d = EXC_PC;
      end else if (eret) begin
         pc_d = epc;
      end else if (stall) begin
         pc_d = pc_q;
      end else if (j_op == 2'd1) begin
         pc_d = j_target;
      end else if (j_op == 2'd2) begin
         pc_d = jr_target;
      end else if (br_taken) begin
         pc_d = br_target;
      end
   end

   // PC register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed scenarios plus a random run
// against an arithmetic reference model of the next-PC rules.

`timescale 1ns/1ps

`ifndef CMP_EQ
`define CMP_EQ  2'd0
`define CMP_GT  2'd1
`define CMP_LT  2'd2
`endif
`ifndef ZERO_EQ
`define ZERO_EQ 2'd0
`define ZERO_GT 2'd1
`define ZERO_LT 2'd2
`endif

module tb_pc_next_unit;

   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_PC = 32'h0000_4180;
   localparam logic [31:0] LO     = 32'h0000_3000;
   localparam logic [31:0] HI     = 32'h0000_6ffc;

   logic        clk = 1'b0;
   logic        reset, stall, exc_req, eret;
   logic [31:0] d_pc, jr_target, epc;
   logic [2:0]  br_op;
   logic [1:0]  cmp, zero, j_op;
   logic [15:0] imm16;
   logic [25:0] instr_index;
   logic [31:0] pc, link_addr;
   logic        br_taken, f_bd, adel_f;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] pc_m;

   pc_next_unit dut (
      .clk(clk), .reset(reset), .stall(stall), .d_pc(d_pc), .br_op(br_op), .cmp(cmp),
      .zero(zero), .imm16(imm16), .j_op(j_op), .instr_index(instr_index),
      .jr_target(jr_target), .exc_req(exc_req), .eret(eret), .epc(epc), .pc(pc),
      .link_addr(link_addr), .br_taken(br_taken), .f_bd(f_bd), .adel_f(adel_f)
   );

   always #5 clk = ~clk;

   function automatic logic m_taken(int b, logic [1:0] c, logic [1:0] z);
      case (b)
         1: return c == `CMP_EQ;
         2: return c != `CMP_EQ;
         3: return (z == `ZERO_EQ) || (z == `ZERO_LT);
         4: return z == `ZERO_GT;
         5: return z == `ZERO_LT;
         6: return (z == `ZERO_EQ) || (z == `ZERO_GT);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic m_adel(logic [31:0] p);
      return (p % 4 != 0) || (p < LO) || (p > HI);
   endfunction

   function automatic logic m_bd(int b, int j);
      return (b >= 1 && b <= 6) || (j == 1 || j == 2);
   endfunction

   // Next PC from the priority list, using plain modular arithmetic.
   function automatic logic [31:0] m_next();
      int s;
      s = $signed(imm16);
      if (!reset) return RST_PC;
      if (exc_req) return EXC_PC;
      if (eret) return epc;
      if (stall) return pc_m;
      if (j_op == 2'd1) return ((d_pc + 32'd4) & 32'hF000_0000) | (32'(instr_index) * 32'd4);
      if (j_op == 2'd2) return jr_target;
      if (m_taken(int'(br_op), cmp, zero)) return d_pc + 32'd4 + 32'(s * 4);
      return pc_m + 32'd4;
   endfunction

   task automatic idle();
      reset = 1'b1; stall = 1'b0; exc_req = 1'b0; eret = 1'b0;
      d_pc = 32'h3000; jr_target = 32'h0; epc = 32'h0;
      br_op = 3'd0; cmp = `CMP_GT; zero = `ZERO_GT; j_op = 2'd0;
      imm16 = 16'h0; instr_index = 26'h0;
   endtask

   // One clock with the model advanced from the inputs present at the edge.
   task automatic step();
      logic [31:0] nxt;
      nxt = m_next();
      @(posedge clk);
      #1;
      pc_m = nxt;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b0;
      step();
      step();
      n_cmp++; if (pc !== 32'h3000) begin n_err++;
         $display("FAIL reset_pc got %h want %h", pc, 32'h3000); end
      n_cmp++; if ({br_taken, f_bd, adel_f} !== 3'b000) begin n_err++;
         $display("FAIL reset_flags got %b want 000", {br_taken, f_bd, adel_f}); end
      reset = 1'b1;
      step();
      n_cmp++; if (pc !== 32'h3004) begin n_err++;
         $display("FAIL seq1 got %h want %h", pc, 32'h3004); end
      step();
      n_cmp++; if (pc !== 32'h3008) begin n_err++;
         $display("FAIL seq2 got %h want %h", pc, 32'h3008); end
      n_cmp++; if (adel_f !== 1'b0) begin n_err++;
         $display("FAIL seq_adel got %b want 0", adel_f); end
   endtask

   task automatic test_branch();
      logic [31:0] prev;
      d_pc = 32'h3010; br_op = 3'd1; cmp = `CMP_EQ; imm16 = 16'hFFFC;
      #1;
      n_cmp++; if (br_taken !== 1'b1) begin n_err++;
         $display("FAIL beq_taken got %b want 1", br_taken); end
      step();
      n_cmp++; if (pc !== 32'h3004) begin n_err++;
         $display("FAIL beq_pc got %h want %h", pc, 32'h3004); end
      cmp = `CMP_GT;
      prev = pc_m;
      #1;
      n_cmp++; if (br_taken !== 1'b0) begin n_err++;
         $display("FAIL beq_nt got %b want 0", br_taken); end
      step();
      n_cmp++; if (pc !== prev + 32'd4) begin n_err++;
         $display("FAIL beq_nt_pc got %h want %h", pc, prev + 32'd4); end
      br_op = 3'd0;
   endtask

   task automatic test_jump();
      d_pc = 32'h3020; j_op = 2'd1; instr_index = 26'h0000C40;
      #1;
      n_cmp++; if (link_addr !== 32'h3028) begin n_err++;
         $display("FAIL j_link got %h want %h", link_addr, 32'h3028); end
      n_cmp++; if (f_bd !== 1'b1) begin n_err++;
         $display("FAIL j_bd got %b want 1", f_bd); end
      step();
      n_cmp++; if (pc !== 32'h3100) begin n_err++;
         $display("FAIL j_pc got %h want %h", pc, 32'h3100); end
      j_op = 2'd0;
   endtask

   task automatic test_stall_exc();
      logic [31:0] held;
      held = pc_m;
      stall = 1'b1; br_op = 3'd4; zero = `ZERO_GT; imm16 = 16'h0040;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (pc !== held) begin n_err++;
            $display("FAIL stall_hold[%0d] got %h want %h", i, pc, held); end
      end
      n_cmp++; if (br_taken !== 1'b1) begin n_err++;
         $display("FAIL stall_taken got %b want 1", br_taken); end
      exc_req = 1'b1;
      step();
      n_cmp++; if (pc !== 32'h4180) begin n_err++;
         $display("FAIL exc_pc got %h want %h", pc, 32'h4180); end
      exc_req = 1'b0; eret = 1'b1; epc = 32'h3050;
      step();
      n_cmp++; if (pc !== 32'h3050) begin n_err++;
         $display("FAIL eret_pc got %h want %h", pc, 32'h3050); end
      idle();
   endtask

   task automatic test_jr();
      j_op = 2'd2; jr_target = 32'h3002;
      step();
      n_cmp++; if (pc !== 32'h3002) begin n_err++;
         $display("FAIL jr_pc got %h want %h", pc, 32'h3002); end
      n_cmp++; if (adel_f !== 1'b1) begin n_err++;
         $display("FAIL jr_mis_adel got %b want 1", adel_f); end
      jr_target = 32'h7000;
      step();
      n_cmp++; if (adel_f !== 1'b1) begin n_err++;
         $display("FAIL jr_hi_adel got %b want 1 (pc %h)", adel_f, pc); end
      jr_target = 32'h6ffc;
      step();
      n_cmp++; if (adel_f !== 1'b0) begin n_err++;
         $display("FAIL jr_top_adel got %b want 0 (pc %h)", adel_f, pc); end
      jr_target = 32'h2ffc;
      step();
      n_cmp++; if (adel_f !== 1'b1) begin n_err++;
         $display("FAIL jr_lo_adel got %b want 1 (pc %h)", adel_f, pc); end
      j_op = 2'd0;
   endtask

   task automatic test_reset_priority();
      exc_req = 1'b1; eret = 1'b1; stall = 1'b1; epc = 32'h5000; reset = 1'b0;
      step();
      n_cmp++; if (pc !== 32'h3000) begin n_err++;
         $display("FAIL rst_prio got %h want %h", pc, 32'h3000); end
      reset = 1'b1;
      step();
      n_cmp++; if (pc !== 32'h4180) begin n_err++;
         $display("FAIL exc_prio got %h want %h", pc, 32'h4180); end
      idle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         reset       = ($urandom_range(0, 31) != 0);
         stall       = ($urandom_range(0, 3) == 0);
         exc_req     = ($urandom_range(0, 15) == 0);
         eret        = ($urandom_range(0, 15) == 0);
         br_op       = 3'($urandom_range(0, 7));
         j_op        = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
         cmp         = 2'($urandom_range(0, 3));
         zero        = 2'($urandom_range(0, 3));
         imm16       = 16'($urandom);
         instr_index = 26'($urandom);
         d_pc        = ($urandom_range(0, 3) == 0) ? $urandom : 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
         jr_target   = ($urandom_range(0, 1) == 0) ? $urandom : 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
         epc         = $urandom;
         #1;
         n_cmp++; if (br_taken !== m_taken(int'(br_op), cmp, zero)) begin n_err++;
            $display("FAIL rnd_taken[%0d] got %b want %b", i, br_taken,
                     m_taken(int'(br_op), cmp, zero)); end
         n_cmp++; if (f_bd !== m_bd(int'(br_op), int'(j_op))) begin n_err++;
            $display("FAIL rnd_bd[%0d] got %b want %b", i, f_bd, m_bd(int'(br_op), int'(j_op))); end
         n_cmp++; if (link_addr !== d_pc + 32'd8) begin n_err++;
            $display("FAIL rnd_link[%0d] got %h want %h", i, link_addr, d_pc + 32'd8); end
         step();
         n_cmp++; if (pc !== pc_m) begin n_err++;
            $display("FAIL rnd_pc[%0d] got %h want %h", i, pc, pc_m); end
         n_cmp++; if (adel_f !== m_adel(pc_m)) begin n_err++;
            $display("FAIL rnd_adel[%0d] got %b want %b", i, adel_f, m_adel(pc_m)); end
      end
      idle();
   endtask

   initial begin
      pc_m = 32'h0;
      idle();
      #2;
      test_reset();
      test_branch();
      test_jump();
      test_stall_exc();
      test_jr();
      test_reset_priority();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Fetch-side program-counter register and next-PC selector for the pipelined MIPS core.
- Sits directly downstream of the D-stage comparator. Consumes its `cmp`/`zero` codes together with the D-stage branch/jump decode, and drives the F-stage PC.
- Also takes exception-entry and eret redirects from the CP0/M stage.
- Flags F-stage fetch address errors (AdEL) and delay-slot status.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_PC, 32'h0000_4180, exception handler entry address.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6ffc, highest legal fetch address.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- stall  in  1  hazard-unit stall; holds the PC.
- d_pc  in  32  PC of the instruction currently in D.
- br_op  in  3  D branch type: 0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez; 7 is reserved and treated as none.
- cmp  in  2  comparator A-vs-B code (header `cmp_eq/`cmp_gt/`cmp_lt).
- zero  in  2  comparator A-vs-0 code (header `zero_eq/`zero_gt/`zero_lt).
- imm16  in  16  D-stage branch offset.
- j_op  in  2  D jump type: 0 none, 1 j/jal (index), 2 jr/jalr (register), 3 reserved and treated as none.
- instr_index  in  26  D-stage jump index.
- jr_target  in  32  forwarded rs value for jr/jalr.
- exc_req  in  1  exception taken this cycle (from CP0).
- eret  in  1  eret committing this cycle.
- epc  in  32  return address from CP0.
- pc  out  32  current F-stage PC (registered).
- link_addr  out  32  d_pc + 8, for jal/jalr/link writeback.
- br_taken  out  1  D-stage branch condition true.
- f_bd  out  1  the F instruction is a delay slot (br_op or j_op in D is non-none).
- adel_f  out  1  F fetch address error.

Behaviour:
- Reset: when reset==0 at a posedge, pc <= RESET_PC. This overrides every other input.
- All other outputs are combinational on pc and the inputs. Values right after reset with idle inputs: br_taken=0, f_bd=0, adel_f=0.
- Next-PC priority, evaluated each posedge with reset==1:
  1. exc_req -> EXC_PC.
  2. eret -> epc.
  3. stall -> hold pc.
  4. j_op==1 -> {d_pc_plus4[31:28], instr_index, 2'b00}.
  5. j_op==2 -> jr_target, taken unmodified.
  6. br_taken -> d_pc + 4 + (sign-extended imm16 << 2).
  7. Otherwise -> pc + 4.
- exc_req and eret ignore stall. If exc_req and eret are both high, exc_req wins.
- Branch conditions:
  - beq: cmp==`cmp_eq.
  - bne: cmp!=`cmp_eq.
  - blez: zero in {`zero_eq, `zero_lt}.
  - bgtz: zero==`zero_gt.
  - bltz: zero==`zero_lt.
  - bgez: zero in {`zero_eq, `zero_gt}.
- br_taken is 0 when br_op is 0 or 7. It is evaluated even during stall, but has no effect on the PC while stalled.
- Arithmetic: all additions are 32-bit modulo 2^32. Wrap-around is not trapped here; a wrapped PC is caught by adel_f on the next cycle.
- Branch/jump latency: redirect is visible on pc one cycle after the instruction is in D unstalled. The F instruction at that time is the delay slot and is never squashed by this block.
- adel_f = (pc[1:0]!=0) | (pc<IM_LO) | (pc>IM_HI), unsigned compare. The PC is still advanced normally; the exception path squashes the fetch.
- A misaligned jr_target is loaded as-is; adel_f rises the following cycle.
- Reset mid-stall or mid-branch: reset wins and pc = RESET_PC next cycle.

Test Plan:
- Reset with reset=0 for 2 cycles, then release with no ops -> pc=0x3000, 0x3004, 0x3008 on consecutive cycles; adel_f=0.
- d_pc=0x3010, br_op=1, cmp=`cmp_eq, imm16=16'hFFFC -> br_taken=1; next pc=0x3004. Repeat with cmp=`cmp_gt -> br_taken=0; pc=previous+4.
- d_pc=0x3020, j_op=1, instr_index=26'h0000C40 -> next pc=0x3100; link_addr=0x3028; f_bd=1.
- stall=1 with br_op=4 and zero=`zero_gt for 3 cycles -> pc constant. Then exc_req=1 while still stalled -> pc=0x4180 next cycle. Then eret=1 with epc=0x3050 -> pc=0x3050.
- j_op=2, jr_target=0x3002 -> pc=0x3002 and adel_f=1. Separately jr_target=0x7000 -> adel_f=1; jr_target=0x6ffc -> adel_f=0.
- exc_req=1, eret=1, stall=1 and reset=0 all in the same cycle -> pc=0x3000. The same stimulus with reset=1 -> pc=0x4180.
